// File: rtl/path_delay_test_ctrl.sv
// Path-delay screening sequencer: launches alternating edges down each selected
// inverter chain, samples the chain after a fixed settle window and tallies bad captures.
module path_delay_test_ctrl #(
   parameter int unsigned NUM_PATHS     = 8,
   parameter int unsigned SEL_W         = 3,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned TRIALS        = 16,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned EXPECT_INV    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CNT_W-1:0]     threshold,
   output logic [NUM_PATHS-1:0] pathInput,
   input  logic [NUM_PATHS-1:0] pathResult,
   output logic                 busy,
   output logic                 res_valid,
   output logic [SEL_W-1:0]     res_path,
   output logic [CNT_W-1:0]     res_errors,
   output logic                 res_flag,
   output logic [NUM_PATHS-1:0] trojan_mask,
   output logic                 done
);

   localparam int unsigned TRIAL_W = (TRIALS > 1) ? $clog2(TRIALS) : 1;
   localparam int unsigned TMR_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TRIAL_W-1:0] TRIAL_LAST = TRIAL_W'(TRIALS - 1);
   localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_PATHS - 1);
   localparam logic               INV        = (EXPECT_INV != 0);

   typedef enum logic [2:0] {
      IDLE, PRECHG, LAUNCH, SETTLE, CAPTURE, CHECK, REPORT, NEXT
   } state_e;

   state_e               state_q, state_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [TRIAL_W-1:0]   trial_q, trial_d;
   logic [CNT_W-1:0]     err_q, err_d;
   logic                 lv_q, lv_d;
   logic                 cap_q, cap_d;
   logic [CNT_W-1:0]     thr_q, thr_d;
   logic [NUM_PATHS-1:0] pin_q, pin_d;
   logic                 res_valid_q, res_valid_d;
   logic [SEL_W-1:0]     res_path_q, res_path_d;
   logic [CNT_W-1:0]     res_errors_q, res_errors_d;
   logic                 res_flag_q, res_flag_d;
   logic [NUM_PATHS-1:0] mask_q, mask_d;
   logic                 done_q, done_d;
   logic                 flag_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         tmr_q        <= '0;
         trial_q      <= '0;
         err_q        <= '0;
         lv_q         <= 1'b0;
         cap_q        <= 1'b0;
         thr_q        <= '0;
         pin_q        <= '0;
         res_valid_q  <= 1'b0;
         res_path_q   <= '0;
         res_errors_q <= '0;
         res_flag_q   <= 1'b0;
         mask_q       <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         tmr_q        <= tmr_d;
         trial_q      <= trial_d;
         err_q        <= err_d;
         lv_q         <= lv_d;
         cap_q        <= cap_d;
         thr_q        <= thr_d;
         pin_q        <= pin_d;
         res_valid_q  <= res_valid_d;
         res_path_q   <= res_path_d;
         res_errors_q <= res_errors_d;
         res_flag_q   <= res_flag_d;
         mask_q       <= mask_d;
         done_q       <= done_d;
      end
   end

   assign flag_now = (err_q > thr_q);

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      tmr_d        = tmr_q;
      trial_d      = trial_q;
      err_d        = err_q;
      lv_d         = lv_q;
      cap_d        = cap_q;
      thr_d        = thr_q;
      pin_d        = pin_q;
      res_valid_d  = 1'b0;
      res_path_d   = res_path_q;
      res_errors_d = res_errors_q;
      res_flag_d   = res_flag_q;
      mask_d       = mask_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               thr_d   = threshold;
               mask_d  = '0;
               sel_d   = '0;
               tmr_d   = '0;
               state_d = PRECHG;
            end
         end
         PRECHG: begin
            pin_d   = '0;
            err_d   = '0;
            trial_d = '0;
            lv_d    = 1'b0;
            if (tmr_q == TMR_LAST) state_d = LAUNCH;
            else                   tmr_d   = tmr_q + TMR_W'(1);
         end
         LAUNCH: begin
            lv_d         = ~lv_q;
            pin_d        = '0;
            pin_d[sel_q] = ~lv_q;
            tmr_d        = '0;
            state_d      = SETTLE;
         end
         // Dwell SETTLE_CYCLES here so the capture edge lands SETTLE_CYCLES+1 edges after launch.
         SETTLE: begin
            if (tmr_q == TMR_LAST) state_d = CAPTURE;
            else                   tmr_d   = tmr_q + TMR_W'(1);
         end
         CAPTURE: begin
            cap_d   = pathResult[sel_q];
            state_d = CHECK;
         end
         CHECK: begin
            if ((cap_q != (lv_q ^ INV)) && (err_q != '1)) err_d = err_q + CNT_W'(1);
            if (trial_q == TRIAL_LAST) begin
               state_d = REPORT;
            end else begin
               trial_d = trial_q + TRIAL_W'(1);
               state_d = LAUNCH;
            end
         end
         REPORT: begin
            res_valid_d   = 1'b1;
            res_path_d    = sel_q;
            res_errors_d  = err_q;
            res_flag_d    = flag_now;
            mask_d[sel_q] = mask_q[sel_q] | flag_now;
            state_d       = NEXT;
         end
         NEXT: begin
            pin_d = '0;
            if (sel_q == SEL_LAST) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               sel_d   = sel_q + SEL_W'(1);
               tmr_d   = '0;
               state_d = PRECHG;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pathInput   = pin_q;
   assign busy        = (state_q != IDLE);
   assign res_valid   = res_valid_q;
   assign res_path    = res_path_q;
   assign res_errors  = res_errors_q;
   assign res_flag    = res_flag_q;
   assign trojan_mask = mask_q;
   assign done        = done_q;

endmodule

// File: tb/tb_path_delay_test_ctrl.sv
// Bench for path_delay_test_ctrl: per-path delayed echo of pathInput, a schedule-based
// reference model checked every cycle, plus directed literal expectations.
module tb_path_delay_test_ctrl;

   localparam int unsigned NP    = 8;
   localparam int unsigned SW    = 3;
   localparam int unsigned S     = 4;
   localparam int unsigned T     = 16;
   localparam int unsigned CW    = 8;
   localparam int unsigned PP    = S + T * (S + 3) + 2;
   localparam int unsigned T2    = 20;
   localparam int unsigned CW2   = 4;
   localparam int unsigned DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic [CW-1:0] thr   = '0;
   logic [NP-1:0] pin, pres, mask;
   logic          busy, rv, rflag, done;
   logic [SW-1:0] rpath;
   logic [CW-1:0] rerr;

   logic           start2 = 1'b0;
   logic [CW2-1:0] thr2   = '0;
   logic [NP-1:0]  pin2, pres2, mask2;
   logic           busy2, rv2, rflag2, done2;
   logic [SW-1:0]  rpath2;
   logic [CW2-1:0] rerr2;

   path_delay_test_ctrl #(
      .NUM_PATHS(NP), .SEL_W(SW), .SETTLE_CYCLES(S), .TRIALS(T), .CNT_W(CW), .EXPECT_INV(0)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .threshold(thr),
      .pathInput(pin), .pathResult(pres), .busy(busy),
      .res_valid(rv), .res_path(rpath), .res_errors(rerr), .res_flag(rflag),
      .trojan_mask(mask), .done(done)
   );

   path_delay_test_ctrl #(
      .NUM_PATHS(NP), .SEL_W(SW), .SETTLE_CYCLES(S), .TRIALS(T2), .CNT_W(CW2), .EXPECT_INV(0)
   ) dut2 (
      .clk(clk), .rst(rst), .start(start2), .threshold(thr2),
      .pathInput(pin2), .pathResult(pres2), .busy(busy2),
      .res_valid(rv2), .res_path(rpath2), .res_errors(rerr2), .res_flag(rflag2),
      .trojan_mask(mask2), .done(done2)
   );

   // Each chain echoes its launch bit D clock cycles later.
   logic [NP-1:0] pipe1 [DEPTH] = '{default: '0};
   logic [NP-1:0] pipe2 [DEPTH] = '{default: '0};
   int unsigned   dly1 [NP] = '{default: 2};
   int unsigned   dly2 [NP] = '{default: 2};

   always @(posedge clk) begin
      pipe1[0] <= pin;
      pipe2[0] <= pin2;
      for (int j = 1; j < DEPTH; j++) begin
         pipe1[j] <= pipe1[j-1];
         pipe2[j] <= pipe2[j-1];
      end
   end

   always_comb begin
      pres  = '0;
      pres2 = '0;
      for (int p = 0; p < NP; p++) begin
         pres[p]  = pipe1[dly1[p]-1][p];
         pres2[p] = pipe2[dly2[p]-1][p];
      end
   end

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Launch value on the selected bit, u cycles into a path window (0 = first precharge cycle).
   function automatic bit drive_at(input int u);
      int m;
      if (u <= int'(S)) return 1'b0;
      m = (u - int'(S) - 1) / int'(S + 3);
      if (m > int'(T) - 1) m = int'(T) - 1;
      return (m % 2) == 0;
   endfunction

   // Trial n captures in path cycle S+n(S+3)+1+S, seeing what was driven D cycles before.
   function automatic int unsigned exp_errs(input int unsigned d);
      int unsigned e;
      int t;
      e = 0;
      for (int n = 0; n < int'(T); n++) begin
         t = int'(S) + n * int'(S + 3) + 1 + int'(S) - int'(d);
         if (drive_at(t) != ((n % 2) == 0)) e++;
      end
      return (e > (2**CW - 1)) ? (2**CW - 1) : e;
   endfunction

   bit            armed = 1'b0;
   bit            m_act = 1'b0, m_rv = 1'b0, m_flag = 1'b0, m_done = 1'b0;
   int unsigned   k = 0, m_path = 0, m_err = 0, m_thr = 0;
   logic [NP-1:0] m_mask = '0;
   int unsigned   m_dly [NP] = '{default: 2};

   // Model state describes the cycle that follows each rising edge.
   initial forever begin
      @(posedge clk);
      armed  = 1'b1;
      m_rv   = 1'b0;
      m_done = 1'b0;
      if (rst) begin
         m_act  = 1'b0;
         k      = 0;
         m_mask = '0;
         m_path = 0;
         m_err  = 0;
         m_flag = 1'b0;
      end else if (m_act) begin
         k++;
         if (k > NP * PP) begin
            m_act  = 1'b0;
            m_done = 1'b1;
         end else if ((k % PP) == 0) begin
            m_path         = k / PP - 1;
            m_err          = exp_errs(m_dly[m_path]);
            m_flag         = (m_err > m_thr);
            m_mask[m_path] = m_mask[m_path] | m_flag;
            m_rv           = 1'b1;
         end
      end else if (start) begin
         m_act  = 1'b1;
         k      = 1;
         m_thr  = thr;
         m_mask = '0;
         for (int p = 0; p < NP; p++) m_dly[p] = dly1[p];
      end
   end

   function automatic logic [NP-1:0] exp_pin();
      logic [NP-1:0] v;
      v = '0;
      if (m_act) v[(k-1)/PP] = drive_at(int'((k-1) % PP));
      return v;
   endfunction

   initial forever begin
      @(negedge clk);
      if (armed) begin
         chk("busy",        busy,  m_act);
         chk("pathInput",   pin,   exp_pin());
         chk("res_valid",   rv,    m_rv);
         chk("res_path",    rpath, m_path);
         chk("res_errors",  rerr,  m_err);
         chk("res_flag",    rflag, m_flag);
         chk("trojan_mask", mask,  m_mask);
         chk("done",        done,  m_done);
      end
   end

   int unsigned cycles, nrv;
   int unsigned rep_err [NP];
   bit          rep_flag [NP];

   // mode 0: quiet; 1: random start pulses and threshold changes; 2: start pulse + threshold 0 at cycle 50
   task automatic run_sweep(input logic [CW-1:0] th, input int mode);
      int unsigned cnt;
      bit seen;
      cnt  = 0;
      seen = 1'b0;
      nrv  = 0;
      for (int p = 0; p < NP; p++) begin
         rep_err[p]  = 9999;
         rep_flag[p] = 1'b0;
      end
      @(negedge clk);
      start = 1'b1;
      thr   = th;
      while (!seen && cnt < 2000) begin
         @(negedge clk);
         cnt++;
         start = 1'b0;
         if (rv) begin
            chk("report_order", rpath, nrv);
            rep_err[rpath]  = rerr;
            rep_flag[rpath] = rflag;
            nrv++;
         end
         if (done) seen = 1'b1;
         else if (mode == 1) begin
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) thr = CW'($urandom);
         end else if (mode == 2 && cnt == 50) begin
            start = 1'b1;
            thr   = '0;
         end
      end
      chk("done_seen", seen, 1);
      cycles = cnt;
   endtask

   initial begin
      int unsigned cnt, n2;
      int          ndone;
      bit          seen, hit;

      // Reset
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_pathInput", pin, 0);
      chk("rst_res_valid", rv, 0);
      chk("rst_res_errors", rerr, 0);
      chk("rst_mask", mask, 0);
      chk("rst_done", done, 0);
      chk("rst_busy2", busy2, 0);
      repeat (18) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // All paths fast, threshold 0
      run_sweep(8'd0, 0);
      chk("sweep_cycles", cycles, 945);
      chk("sweep_reports", nrv, 8);
      chk("sweep_mask", mask, 8'h00);
      for (int p = 0; p < NP; p++) chk("clean_errors", rep_err[p], 0);

      // Slow path 3, threshold 3
      dly1[3] = 6;
      repeat (5) @(negedge clk);
      run_sweep(8'd3, 0);
      chk("slow_errors", rep_err[3], 16);
      chk("slow_flag", rep_flag[3], 1);
      chk("slow_mask", mask, 8'h08);
      chk("fast_errors", rep_err[2], 0);
      dly1[3] = 2;

      // Latched threshold 16 with a 16-error path; restart attempt and threshold 0 mid-sweep
      dly1[1] = 6;
      dly1[6] = 12;
      repeat (5) @(negedge clk);
      run_sweep(8'd16, 2);
      chk("latched_cycles", cycles, 945);
      chk("eq_thr_errors", rep_err[1], 16);
      chk("eq_thr_flag", rep_flag[1], 0);
      chk("one_err_errors", rep_err[6], 1);
      chk("latched_mask", mask, 8'h00);
      dly1[1] = 2;
      dly1[6] = 2;

      // Reset during path 2 settle
      repeat (5) @(negedge clk);
      start = 1'b1;
      thr   = 8'd0;
      hit   = 1'b0;
      cnt   = 0;
      while (!hit && cnt < 400) begin
         @(negedge clk);
         cnt++;
         start = 1'b0;
         if (m_act && k == 2 * PP + 1 + S + 2) hit = 1'b1;
      end
      chk("abort_point_reached", hit, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_pathInput", pin, 0);
      rst   = 1'b0;
      ndone = 0;
      repeat (150) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run_sweep(8'd0, 0);
      chk("post_abort_cycles", cycles, 945);
      chk("post_abort_reports", nrv, 8);
      chk("post_abort_mask", mask, 8'h00);

      // Randomized sweeps
      repeat (6) begin
         for (int p = 0; p < NP; p++) dly1[p] = $urandom_range(1, 15);
         repeat ($urandom_range(3, 12)) @(negedge clk);
         run_sweep(CW'($urandom_range(0, 20)), 1);
         chk("rand_cycles", cycles, 945);
         chk("rand_reports", nrv, 8);
      end

      // Saturating 4-bit counter, 20 trials
      for (int p = 0; p < NP; p++) dly2[p] = 2;
      dly2[0] = 10;
      repeat (20) @(negedge clk);
      start2 = 1'b1;
      thr2   = 4'd3;
      cnt    = 0;
      n2     = 0;
      seen   = 1'b0;
      while (!seen && cnt < 3000) begin
         @(negedge clk);
         cnt++;
         start2 = 1'b0;
         if (rv2) begin
            chk("report2_order", rpath2, n2);
            if (rpath2 == 0) begin
               chk("sat_errors", rerr2, 15);
               chk("sat_flag", rflag2, 1);
            end else begin
               chk("clean2_errors", rerr2, 0);
            end
            n2++;
         end
         if (done2) seen = 1'b1;
      end
      chk("done2_seen", seen, 1);
      chk("sweep2_cycles", cnt, 1 + NP * (S + T2 * (S + 3) + 2));
      chk("sweep2_reports", n2, 8);
      chk("sweep2_mask", mask2, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
